// File: rtl/block_data_memory.sv
// block_data_memory: block-organised data memory behind the data cache.
// Serves whole-block refills (read) and write-backs (write) with a fixed,
// counter-based latency and a read/write/busywait stall handshake.
// Storage is little-endian within a block: byte k of a block occupies
// bits [8k+7:8k] of readdata/writedata.
//
// Ports:
//   clock      in   system clock, all state changes on posedge
//   reset      in   synchronous active-high reset
//   read       in   block read request, level-held by the requester
//   write      in   block write request, level-held by the requester
//   address    in   block address (ADDR_W bits)
//   writedata  in   block to write (BLK_W bits)
//   readdata   out  last block read (BLK_W bits)
//   busywait   out  stall to the requester
//   error      out  sticky flag, read and write were asserted together
module block_data_memory #(
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned LATENCY     = 5,
    localparam int unsigned BLK_W      = WORD_W * BLOCK_WORDS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [BLK_W-1:0]  writedata,
    output logic [BLK_W-1:0]  readdata,
    output logic              busywait,
    output logic              error
);

    localparam int unsigned CNT_W  = $clog2(LATENCY + 1);
    localparam int unsigned BLOCKS = 2 ** ADDR_W;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                op_wr_q, op_wr_d;
    logic [BLK_W-1:0]    wdata_q, wdata_d;
    logic [BLK_W-1:0]    rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                mem_we;

    // Whole-block rows; a row holds its bytes little-endian, which is the
    // same layout as a flat byte array indexed by A*BB+k.
    logic [BLK_W-1:0]    mem_q [BLOCKS];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        op_wr_d = op_wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (read ^ write) begin
                    addr_d  = address;
                    op_wr_d = write;
                    wdata_d = write ? writedata : wdata_q;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = StBusy;
                end else if (read && write) begin
                    err_d = 1'b1;
                end
            end
            StBusy: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (op_wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem_q[addr_q];
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Stall rises combinationally with the request so the requester never
    // sees a cycle of apparent completion before the access is accepted.
    assign busywait = !reset && (((state_q == StIdle) && (read ^ write)) || (state_q == StBusy));
    assign readdata = rdata_q;
    assign error    = err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            op_wr_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < int'(BLOCKS); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            op_wr_q <= op_wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (mem_we) begin
                mem_q[addr_q] <= wdata_q;
            end
        end
    end

endmodule
